// File: rtl/uart_program_loader.sv
// UART 8N1 program loader: fills instruction memory and holds the core in reset until done.
// Optional trailing 16-bit image checksum when LOADER_CHECKSUM_EN is defined.
module uart_program_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 10
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              core_reset,
  output logic              loading,
  output logic              done,
  output logic              err
);

  localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0] DEPTH   = 17'(2 ** ADDR_W);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] LEN_HI  = 3'd0;
  localparam logic [2:0] LEN_LO  = 3'd1;
  localparam logic [2:0] DATA_HI = 3'd2;
  localparam logic [2:0] DATA_LO = 3'd3;
  localparam logic [2:0] DONE    = 3'd6;
  localparam logic [2:0] ERROR   = 3'd7;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] CSUM_HI = 3'd4;
  localparam logic [2:0] CSUM_LO = 3'd5;
  localparam logic [2:0] TAIL    = CSUM_HI;
`else
  localparam logic [2:0] TAIL    = DONE;
`endif

  logic       rx_s1, rx_s2, rx_q;
  logic [1:0] rx_st;
  logic [15:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic       byte_valid, frame_err;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_q  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_q  <= rx_s2;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      rx_st      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_st)
        RX_IDLE:
          if (rx_q && !rx_s2) begin
            rx_st <= RX_START;
            cnt   <= '0;
          end
        RX_START:
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            rx_st   <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        RX_DATA:
          if (cnt == BIT_M1) begin
            cnt     <= '0;
            shreg   <= {rx_s2, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) rx_st <= RX_STOP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        default:
          if (cnt == BIT_M1) begin
            cnt        <= '0;
            rx_st      <= RX_IDLE;
            byte_valid <= rx_s2;
            frame_err  <= !rx_s2;
          end else begin
            cnt <= cnt + 16'd1;
          end
      endcase
    end
  end

  logic [2:0]        st;
  logic [7:0]        hi;
  logic [ADDR_W-1:0] idx, last;
  logic [15:0]       word;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0]       sum;
`endif

  assign word = {hi, shreg};

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      st        <= LEN_HI;
      hi        <= '0;
      idx       <= '0;
      last      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum       <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      if (frame_err && st != DONE) begin
        st <= ERROR;
      end else if (byte_valid) begin
        case (st)
          LEN_HI: begin
            hi <= shreg;
            st <= LEN_LO;
          end
          LEN_LO: begin
            last <= ADDR_W'(word - 16'd1);
            idx  <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum  <= word;
`endif
            if ({1'b0, word} > DEPTH) st <= ERROR;
            else if (word == 16'd0)   st <= TAIL;
            else                      st <= DATA_HI;
          end
          DATA_HI: begin
            hi <= shreg;
            st <= DATA_LO;
          end
          DATA_LO: begin
            mem_we    <= 1'b1;
            mem_addr  <= idx;
            mem_wdata <= word;
`ifdef LOADER_CHECKSUM_EN
            sum       <= sum + word;
`endif
            if (idx == last) begin
              st <= TAIL;
            end else begin
              idx <= idx + 1'b1;
              st  <= DATA_HI;
            end
          end
`ifdef LOADER_CHECKSUM_EN
          CSUM_HI: begin
            hi <= shreg;
            st <= CSUM_LO;
          end
          CSUM_LO: st <= (word == sum) ? DONE : ERROR;
`endif
          default: st <= st;
        endcase
      end
    end
  end

  // loading is visible in the same cycle as the first length byte strobe
  assign loading    = (st == LEN_HI) ? byte_valid
                    : !(st == DONE || st == ERROR);
  assign done       = (st == DONE);
  assign err        = (st == ERROR);
  assign core_reset = (st != DONE);

endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader: vector table plus
// hand sequences, with a write scoreboard on the memory port.
module tb_uart_program_loader;

  localparam int CPB = 8;
  localparam int AW  = 4;

  logic          CLK = 1'b0;
  logic          reset;
  logic          rx;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          core_reset, loading, done, err;

  uart_program_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .CLK(CLK), .reset(reset), .rx(rx),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_reset(core_reset), .loading(loading),
    .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [15:0]   d;
  } wr_t;
  wr_t q[$];

  typedef struct {
    logic [7:0]    b [8];
    int            nb;
    int            body;
    bit            csum;
    bit            last_stop;
    int            nw;
    logic [AW-1:0] wa [2];
    logic [15:0]   wd [2];
    bit            exp_done;
    bit            exp_err;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  logic we_q = 1'b0;
  always @(negedge CLK) begin
    if (mem_we) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr=%0h data=%h expected none",
                 mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.a));
        chk("wr_data", 32'(mem_wdata), 32'(e.d));
      end
    end
    if (mem_we && we_q) begin
      checks++;
      errors++;
      $display("FAIL back_to_back: got two strobes expected one");
    end
    we_q = mem_we;
  end

  task automatic send_byte(input logic [7:0] b, input bit stop);
    @(negedge CLK);
    rx = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge CLK);
    end
    rx = stop;
    repeat (CPB) @(negedge CLK);
    rx = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic send_word(input logic [15:0] w);
    send_byte(w[15:8], 1'b1);
    send_byte(w[7:0], 1'b1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"},    32'(mem_we), 32'd0);
    chk({tag, "_addr"},  32'(mem_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_crst"},  32'(core_reset), 32'd1);
    chk({tag, "_load"},  32'(loading), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_err"},   32'(err), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    reset = 1'b0;
    repeat (3) @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
  endtask

  task automatic chk_end(input string tag, input bit d, input bit e);
    repeat (5) @(negedge CLK);
    chk({tag, "_done"}, 32'(done), 32'(d));
    chk({tag, "_err"},  32'(err), 32'(e));
    chk({tag, "_crst"}, 32'(core_reset), 32'(!d));
    chk({tag, "_load"}, 32'(loading), 32'd0);
    chk({tag, "_pend"}, 32'(q.size()), 32'd0);
  endtask

  task automatic run_case(input vec_t v, input int k);
    logic [15:0] s;
    string tag;
    tag = $sformatf("case%0d", k);
    s = '0;
    for (int i = 0; i + 1 < v.body; i += 2) s += {v.b[i], v.b[i+1]};
    do_reset();
    for (int w = 0; w < v.nw; w++) q.push_back('{a: v.wa[w], d: v.wd[w]});
    for (int i = 0; i <= v.nb; i++) begin
`ifdef LOADER_CHECKSUM_EN
      if (i == v.body && v.csum) send_word(s);
`endif
      if (i < v.nb) send_byte(v.b[i], (i == v.nb - 1) ? v.last_stop : 1'b1);
    end
    chk_end(tag, v.exp_done, v.exp_err);
  endtask

  initial begin
    rx    = 1'b1;
    reset = 1'b0;

    tbl[0] = '{b: '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h00},
               nb: 6, body: 6, csum: 1, last_stop: 1, nw: 2,
               wa: '{4'd0, 4'd1}, wd: '{16'h1234, 16'hABCD},
               exp_done: 1, exp_err: 0};
    tbl[1] = '{b: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               nb: 2, body: 2, csum: 1, last_stop: 1, nw: 0,
               wa: '{4'd0, 4'd0}, wd: '{16'h0, 16'h0},
               exp_done: 1, exp_err: 0};
    tbl[2] = '{b: '{8'h00, 8'h11, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00},
               nb: 4, body: 4, csum: 0, last_stop: 1, nw: 0,
               wa: '{4'd0, 4'd0}, wd: '{16'h0, 16'h0},
               exp_done: 0, exp_err: 1};
    tbl[3] = '{b: '{8'h00, 8'h01, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00},
               nb: 4, body: 4, csum: 0, last_stop: 0, nw: 0,
               wa: '{4'd0, 4'd0}, wd: '{16'h0, 16'h0},
               exp_done: 0, exp_err: 1};
    tbl[4] = '{b: '{8'h00, 8'h01, 8'h00, 8'h07, 8'hFF, 8'hFF, 8'h00, 8'h00},
               nb: 6, body: 4, csum: 1, last_stop: 1, nw: 1,
               wa: '{4'd0, 4'd0}, wd: '{16'h0007, 16'h0},
               exp_done: 1, exp_err: 0};

    repeat (2) @(negedge CLK);
    chk_reset_vals("rst");
    reset = 1'b1;

    for (int k = 0; k < 5; k++) run_case(tbl[k], k);

    // full-depth image reaches the top address exactly
    begin
      logic [15:0] s;
      do_reset();
      s = 16'd16;
      send_word(16'd16);
      for (int i = 0; i < 16; i++) begin
        logic [15:0] w;
        w = 16'hC000 + 16'(i * 16'h0101);
        s += w;
        q.push_back('{a: AW'(i), d: w});
        send_word(w);
      end
`ifdef LOADER_CHECKSUM_EN
      send_word(s);
`endif
      chk_end("depth", 1'b1, 1'b0);
      chk("depth_addr_hold", 32'(mem_addr), 32'd15);
    end

    // short rx glitch must read as a false start
    do_reset();
    send_byte(8'h00, 1'b1);
    chk("glitch_load_pre", 32'(loading), 32'd1);
    @(negedge CLK);
    rx = 1'b0;
    repeat (2) @(negedge CLK);
    rx = 1'b1;
    repeat (20) @(negedge CLK);
    chk("glitch_err", 32'(err), 32'd0);
    chk("glitch_load", 32'(loading), 32'd1);
    q.push_back('{a: 4'd0, d: 16'h1234});
    send_byte(8'h01, 1'b1);
    send_word(16'h1234);
`ifdef LOADER_CHECKSUM_EN
    send_word(16'h1235);
`endif
    chk_end("glitch", 1'b1, 1'b0);

    // reset mid-load and mid-byte, then reload
    do_reset();
    q.push_back('{a: 4'd0, d: 16'hAAAA});
    send_word(16'h0003);
    send_word(16'hAAAA);
    repeat (4) @(negedge CLK);
    chk("mid_pend", 32'(q.size()), 32'd0);
    chk("mid_load", 32'(loading), 32'd1);
    rx = 1'b0;
    repeat (20) @(negedge CLK);
    reset = 1'b0;
    #1;
    chk_reset_vals("midrst");
    rx = 1'b1;
    repeat (3) @(negedge CLK);
    reset = 1'b1;
    q.push_back('{a: 4'd0, d: 16'h5AA5});
    send_word(16'h0001);
    send_word(16'h5AA5);
`ifdef LOADER_CHECKSUM_EN
    send_word(16'h5AA6);
`endif
    chk_end("reload", 1'b1, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    do_reset();
    q.push_back('{a: 4'd0, d: 16'h5AA5});
    send_word(16'h0001);
    send_word(16'h5AA5);
    send_word(16'h0000);
    chk_end("badsum", 1'b0, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
